// File: rtl/onchip_mem_sweep_master_if.sv
// Avalon-MM bus between the sweep master and the on-chip memory's s2 slave.
interface onchip_mem_sweep_master_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              clken;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write, writedata, byteenable, clken,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, writedata, byteenable, clken,
    output readdata
  );
endinterface

// File: rtl/onchip_mem_sweep_master.sv
// Sweeps the on-chip memory into a shadow register file, flags changed words,
// and issues a single byte-enabled status writeback on request.
module onchip_mem_sweep_master #(
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned NUM_WORDS    = 4,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WB_ADDR      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          wb_req,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic [DATA_W/8-1:0]           wb_byteenable,
  output logic                          wb_ack,
  onchip_mem_sweep_master_if.master     avm,
  output logic [NUM_WORDS*DATA_W-1:0]   shadow_data,
  output logic                          shadow_valid,
  output logic [NUM_WORDS-1:0]          changed_mask,
  output logic                          update,
  output logic                          busy,
  output logic                          overrun
);
  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned RL   = READ_LATENCY;
  localparam int unsigned SH_W = NUM_WORDS * DATA_W;

  typedef enum logic [2:0] {IDLE, WRITE, ISSUE, DRAIN, COMMIT} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   address_q, address_n;
  logic                cs_q, cs_n, wr_q, wr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
  logic [BE_W-1:0]     be_q, be_n;
  logic                ack_n, upd_n, busy_n;
  logic                start_pending, pend_n, ovr_n;
  logic [SH_W-1:0]     staging, stage_n;
  logic [NUM_WORDS-1:0] mask_n;
  logic                drain_done;
  logic [RL-1:0]       pipe_valid;
  logic [ADDR_W-1:0]   pipe_idx [RL];

  assign avm.address    = address_q;
  assign avm.chipselect = cs_q;
  assign avm.write      = wr_q;
  assign avm.writedata  = wdata_q;
  assign avm.byteenable = be_q;
  assign avm.clken      = 1'b1;

  // Bus outputs are registered from the next state so they line up with it.
  always_comb begin
    state_next = state;
    address_n  = address_q;
    cs_n       = 1'b0;
    wr_n       = 1'b0;
    wdata_n    = wdata_q;
    be_n       = '1;
    ack_n      = 1'b0;
    upd_n      = 1'b0;
    pend_n     = start_pending;
    ovr_n      = overrun;
    stage_n    = staging;
    mask_n     = '0;
    drain_done = 1'b1;

    for (int i = 0; i < int'(RL) - 1; i++) begin
      if (pipe_valid[i]) drain_done = 1'b0;
    end

    if (start) begin
      if (start_pending) ovr_n = 1'b1;
      if (state != IDLE || wb_req) pend_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (wb_req) begin
          state_next = WRITE;
        end else if (start || start_pending) begin
          state_next = ISSUE;
          pend_n     = 1'b0;
        end
      end
      WRITE:  state_next = IDLE;
      ISSUE:  if (address_q == ADDR_W'(NUM_WORDS - 1)) state_next = DRAIN;
      DRAIN:  if (drain_done) state_next = COMMIT;
      COMMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    case (state_next)
      WRITE: begin
        cs_n      = 1'b1;
        wr_n      = 1'b1;
        address_n = ADDR_W'(WB_ADDR);
        wdata_n   = wb_data;
        be_n      = wb_byteenable;
        ack_n     = 1'b1;
      end
      ISSUE: begin
        cs_n      = 1'b1;
        address_n = (state == ISSUE) ? address_q + ADDR_W'(1) : '0;
      end
      COMMIT: upd_n = 1'b1;
      default: ;
    endcase
    busy_n = (state_next != IDLE);

    // The last read lands in the same edge that enters COMMIT, so merge it here.
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (pipe_valid[RL-1] && pipe_idx[RL-1] == ADDR_W'(k))
        stage_n[k*DATA_W +: DATA_W] = avm.readdata;
      mask_n[k] = !shadow_valid ||
                  (stage_n[k*DATA_W +: DATA_W] != shadow_data[k*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      address_q     <= '0;
      cs_q          <= 1'b0;
      wr_q          <= 1'b0;
      wdata_q       <= '0;
      be_q          <= '1;
      wb_ack        <= 1'b0;
      update        <= 1'b0;
      busy          <= 1'b0;
      start_pending <= 1'b0;
      overrun       <= 1'b0;
      staging       <= '0;
      shadow_data   <= '0;
      shadow_valid  <= 1'b0;
      changed_mask  <= '0;
      pipe_valid    <= '0;
      for (int i = 0; i < int'(RL); i++) pipe_idx[i] <= '0;
    end else begin
      state         <= state_next;
      address_q     <= address_n;
      cs_q          <= cs_n;
      wr_q          <= wr_n;
      wdata_q       <= wdata_n;
      be_q          <= be_n;
      wb_ack        <= ack_n;
      update        <= upd_n;
      busy          <= busy_n;
      start_pending <= pend_n;
      overrun       <= ovr_n;
      staging       <= stage_n;
      pipe_valid[0] <= (state == ISSUE);
      pipe_idx[0]   <= address_q;
      for (int i = 1; i < int'(RL); i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_idx[i]   <= pipe_idx[i-1];
      end
      if (state_next == COMMIT) begin
        shadow_data  <= stage_n;
        changed_mask <= mask_n;
        shadow_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_onchip_mem_sweep_master.sv
// Directed bench: two masters (read latency 1 and 2), each with a behavioural memory.
module tb_onchip_mem_sweep_master;
  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b, wb_req;
  logic [31:0] wb_data;
  logic [3:0]  wb_be;
  logic        ack_a, ack_b;
  logic [127:0] shadow_a, shadow_b;
  logic        valid_a, valid_b, upd_a, upd_b, busy_a, busy_b, ovr_a, ovr_b;
  logic [3:0]  mask_a, mask_b;

  logic        ext_we;
  logic [1:0]  ext_addr;
  logic [31:0] ext_data;
  logic [31:0] mem_a [4];
  logic [31:0] mem_b [4];
  logic [31:0] rd_b1;

  logic        sel;
  logic        cs_m, wr_m, upd_m;
  logic [1:0]  addr_m;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  onchip_mem_sweep_master_if #(.ADDR_W(2), .DATA_W(32)) if_a ();
  onchip_mem_sweep_master_if #(.ADDR_W(2), .DATA_W(32)) if_b ();

  onchip_mem_sweep_master #(.READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .wb_req(wb_req),
    .wb_data(wb_data), .wb_byteenable(wb_be), .wb_ack(ack_a), .avm(if_a.master),
    .shadow_data(shadow_a), .shadow_valid(valid_a), .changed_mask(mask_a),
    .update(upd_a), .busy(busy_a), .overrun(ovr_a)
  );

  onchip_mem_sweep_master #(.READ_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .wb_req(1'b0),
    .wb_data(32'h0), .wb_byteenable(4'h0), .wb_ack(ack_b), .avm(if_b.master),
    .shadow_data(shadow_b), .shadow_valid(valid_b), .changed_mask(mask_b),
    .update(upd_b), .busy(busy_b), .overrun(ovr_b)
  );

  // Memory models: latency 1 and latency 2, plus a second port for the bench.
  always @(posedge clk) begin
    if (ext_we) begin
      mem_a[ext_addr] <= ext_data;
      mem_b[ext_addr] <= ext_data;
    end
    if (if_a.chipselect && if_a.write)
      for (int i = 0; i < 4; i++)
        if (if_a.byteenable[i]) mem_a[if_a.address][i*8 +: 8] <= if_a.writedata[i*8 +: 8];
    if_a.readdata <= mem_a[if_a.address];
    rd_b1         <= mem_b[if_b.address];
    if_b.readdata <= rd_b1;
  end

  always_comb begin
    cs_m   = sel ? if_b.chipselect : if_a.chipselect;
    wr_m   = sel ? if_b.write      : if_a.write;
    addr_m = sel ? if_b.address    : if_a.address;
    upd_m  = sel ? upd_b           : upd_a;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_write(input logic [1:0] a, input logic [31:0] d);
    ext_we = 1'b1; ext_addr = a; ext_data = d;
    tick();
    ext_we = 1'b0;
  endtask

  // Counts cycles until update, checking reads are 0..N-1 on consecutive cycles.
  task automatic wait_update(input string tag, input int exp_cyc, input int exp_reads);
    int n = 0;
    int rd = 0;
    int first = 0;
    while (!upd_m && n < 40) begin
      if (cs_m && !wr_m) begin
        if (rd == 0) first = n;
        check({tag, "_addr"}, 128'(addr_m), 128'(rd));
        check({tag, "_seq"}, 128'(n - first), 128'(rd));
        rd++;
      end
      tick();
      n++;
    end
    check({tag, "_lat"}, 128'(n), 128'(exp_cyc));
    check({tag, "_reads"}, 128'(rd), 128'(exp_reads));
  endtask

  initial begin
    int ups;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; wb_req = 1'b0;
    wb_data = '0; wb_be = '0; ext_we = 1'b0; ext_addr = '0; ext_data = '0; sel = 1'b0;
    tick();
    ext_write(2'd0, 32'h1111_1111);
    ext_write(2'd1, 32'h2222_2222);
    ext_write(2'd2, 32'h3333_3333);
    ext_write(2'd3, 32'h4444_4444);
    reset = 1'b0;

    check("rst_busy", 128'(busy_a), 128'(0));
    check("rst_valid", 128'(valid_a), 128'(0));
    check("rst_update", 128'(upd_a), 128'(0));
    check("rst_cs", 128'(if_a.chipselect), 128'(0));
    check("rst_clken", 128'(if_a.clken), 128'(1));
    check("rst_be", 128'(if_a.byteenable), 128'(4'hF));
    check("rst_mask", 128'(mask_a), 128'(0));
    check("rst_shadow", shadow_a, 128'(0));
    check("rst_valid_b", 128'(valid_b), 128'(0));

    // First sweep: all words new.
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_update("s1", 5, 4);
    check("s1_shadow", shadow_a, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    check("s1_mask", 128'(mask_a), 128'(4'b1111));
    check("s1_valid", 128'(valid_a), 128'(1));
    tick();
    check("s1_upd_pulse", 128'(upd_a), 128'(0));

    // Word 2 changed through the other port.
    ext_write(2'd2, 32'h1234_5678);
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_update("s2", 5, 4);
    check("s2_shadow", shadow_a, 128'h4444_4444_1234_5678_2222_2222_1111_1111);
    check("s2_mask", 128'(mask_a), 128'(4'b0100));
    tick();

    // Writeback together with start: write wins, sweep follows.
    wb_req = 1'b1; wb_data = 32'hDEAD_BEEF; wb_be = 4'b0011; start_a = 1'b1;
    tick(); start_a = 1'b0;
    check("wb_ack", 128'(ack_a), 128'(1));
    check("wb_cs", 128'(if_a.chipselect), 128'(1));
    check("wb_write", 128'(if_a.write), 128'(1));
    check("wb_addr", 128'(if_a.address), 128'(3));
    check("wb_be", 128'(if_a.byteenable), 128'(4'b0011));
    check("wb_data", 128'(if_a.writedata), 128'(32'hDEAD_BEEF));
    wb_req = 1'b0;
    tick();
    check("wb_ack_drop", 128'(ack_a), 128'(0));
    check("wb_idle", 128'(busy_a), 128'(0));
    wait_update("s3", 6, 4);
    check("s3_shadow", shadow_a, 128'h4444_BEEF_1234_5678_2222_2222_1111_1111);
    check("s3_mask", 128'(mask_a), 128'(4'b1000));
    tick();

    // Start during a sweep queues one more; a further start is an overrun.
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); start_a = 1'b1; tick(); start_a = 1'b0;
    check("s4_no_ovr", 128'(ovr_a), 128'(0));
    tick(); start_a = 1'b1; tick(); start_a = 1'b0;
    check("s4_ovr", 128'(ovr_a), 128'(1));
    wait_update("s4a", 1, 0);
    tick();
    wait_update("s4b", 6, 4);
    check("s4_mask", 128'(mask_a), 128'(4'b0000));
    check("s4_ovr_sticky", 128'(ovr_a), 128'(1));
    tick();
    check("s4_idle", 128'(busy_a), 128'(0));

    // Reset during the sweep aborts without committing.
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("s5_busy", 128'(busy_a), 128'(0));
    check("s5_valid", 128'(valid_a), 128'(0));
    check("s5_ovr", 128'(ovr_a), 128'(0));
    check("s5_cs", 128'(if_a.chipselect), 128'(0));
    ups = 0;
    for (int i = 0; i < 10; i++) begin
      if (upd_a) ups++;
      tick();
    end
    check("s5_no_update", 128'(ups), 128'(0));
    check("s5_shadow", shadow_a, 128'(0));

    // Read latency 2: one extra cycle, same data placement.
    sel = 1'b1;
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_update("s6", 6, 4);
    check("s6_shadow", shadow_b, 128'h4444_4444_1234_5678_2222_2222_1111_1111);
    check("s6_mask", 128'(mask_b), 128'(4'b1111));
    check("s6_valid", 128'(valid_b), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
